// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: request/strobe/status bundle between a FIFO's users and its
// pointer/flag controller.
//   master: drives push/pop, observes strobes, addresses, count and flags.
//   slave : the controller; consumes push/pop, drives everything else.
interface fifo_ctrl_if #(
    parameter int unsigned MAIN_QUEUE_SIZE = 3
);
    logic                       push;
    logic                       pop;
    logic                       write;
    logic                       read;
    logic [MAIN_QUEUE_SIZE-1:0] ptr_write;
    logic [MAIN_QUEUE_SIZE-1:0] ptr_read;
    logic [MAIN_QUEUE_SIZE:0]   count;
    logic                       full;
    logic                       empty;
    logic                       almost_full;
    logic                       almost_empty;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output push, pop,
        input  write, read, ptr_write, ptr_read, count,
        input  full, empty, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  push, pop,
        output write, read, ptr_write, ptr_read, count,
        output full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller for a FIFO storage memory.
// Turns push/pop requests into memory write/read strobes and addresses,
// tracks occupancy and reports full/empty/almost flags and error status.
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; clears pointers, count and errors
//   bus   - fifo_ctrl_if.slave: push/pop in; write/read (combinational),
//           ptr_write/ptr_read/count/flags/overflow/underflow (registered) out
//
// Build option:
//   FIFO_CTRL_STICKY_ERR_EN - overflow/underflow hold until reset; when
//   undefined each rejected request gives a one-cycle pulse.
module fifo_ctrl #(
    parameter int unsigned MAIN_QUEUE_SIZE = 3,
    parameter int unsigned ALMOST_FULL_TH  = 6,
    parameter int unsigned ALMOST_EMPTY_TH = 2
) (
    input  logic          clk,
    input  logic          reset,
    fifo_ctrl_if.slave    bus
);
    localparam int unsigned PW    = MAIN_QUEUE_SIZE;
    localparam int unsigned CW    = MAIN_QUEUE_SIZE + 1;
    localparam int unsigned DEPTH = 1 << MAIN_QUEUE_SIZE;

    logic [PW-1:0] ptr_write_q;
    logic [PW-1:0] ptr_read_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic          full_q;
    logic          empty_q;
    logic          almost_full_q;
    logic          almost_empty_q;
    logic          overflow_q;
    logic          underflow_q;
    logic          overflow_nxt;
    logic          underflow_nxt;
    logic          write_c;
    logic          read_c;
    logic          rej_push;
    logic          rej_pop;

    // Accept logic and next occupancy; a pop frees a slot for a push even when full.
    always_comb begin
        write_c       = 1'b0;
        read_c        = 1'b0;
        count_nxt     = count_q;
        rej_push      = 1'b0;
        rej_pop       = 1'b0;
        overflow_nxt  = 1'b0;
        underflow_nxt = 1'b0;

        if (!reset) begin
            write_c = bus.push & (~full_q | bus.pop);
            read_c  = bus.pop & ~empty_q;
        end

        case ({write_c, read_c})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase

        rej_push = bus.push & ~write_c;
        rej_pop  = bus.pop & ~read_c;

`ifdef FIFO_CTRL_STICKY_ERR_EN
        overflow_nxt  = overflow_q | rej_push;
        underflow_nxt = underflow_q | rej_pop;
`else
        overflow_nxt  = rej_push;
        underflow_nxt = rej_pop;
`endif
    end

    // Pointers wrap naturally at 2**MAIN_QUEUE_SIZE; flags follow the next count.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_write_q    <= '0;
            ptr_read_q     <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            if (write_c) ptr_write_q <= ptr_write_q + PW'(1);
            if (read_c)  ptr_read_q  <= ptr_read_q + PW'(1);
            count_q        <= count_nxt;
            full_q         <= (count_nxt == CW'(DEPTH));
            empty_q        <= (count_nxt == '0);
            almost_full_q  <= (count_nxt >= CW'(ALMOST_FULL_TH));
            almost_empty_q <= (count_nxt <= CW'(ALMOST_EMPTY_TH));
            overflow_q     <= overflow_nxt;
            underflow_q    <= underflow_nxt;
        end
    end

    assign bus.write        = write_c;
    assign bus.read         = read_c;
    assign bus.ptr_write    = ptr_write_q;
    assign bus.ptr_read     = ptr_read_q;
    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl with a behavioural storage memory.
module tb_fifo_ctrl;
    typedef enum int {F_W, F_R, F_PW, F_PR, F_CNT, F_FULL, F_EMPTY,
                      F_AF, F_AE, F_OV, F_UN} fld_e;

    typedef struct {
        string tag;
        fld_e  fld;
        int    val;
    } exp_t;

    logic clk;
    logic reset;
    logic [11:0] din;
    logic [11:0] mem [8];
    logic [11:0] mem_out;

    fifo_ctrl_if #(.MAIN_QUEUE_SIZE(3)) bus ();

    fifo_ctrl #(
        .MAIN_QUEUE_SIZE(3),
        .ALMOST_FULL_TH (6),
        .ALMOST_EMPTY_TH(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Storage memory: write lands at the edge, read is combinational.
    always_ff @(posedge clk) if (bus.write) mem[bus.ptr_write] <= din;
    assign mem_out = mem[bus.ptr_read];

    exp_t        exp_q [$];
    logic [11:0] data_exp [$];
    logic [11:0] model_q [$];
    int n_chk  = 0;
    int n_pass = 0;

    // Reference state of the controller as described by its behaviour.
    int m_cnt = 0;
    int m_pw  = 0;
    int m_pr  = 0;
    int m_ov  = 0;
    int m_un  = 0;

    function automatic logic [31:0] actual(fld_e f);
        case (f)
            F_W:     return 32'(bus.write);
            F_R:     return 32'(bus.read);
            F_PW:    return 32'(bus.ptr_write);
            F_PR:    return 32'(bus.ptr_read);
            F_CNT:   return 32'(bus.count);
            F_FULL:  return 32'(bus.full);
            F_EMPTY: return 32'(bus.empty);
            F_AF:    return 32'(bus.almost_full);
            F_AE:    return 32'(bus.almost_empty);
            F_OV:    return 32'(bus.overflow);
            default: return 32'(bus.underflow);
        endcase
    endfunction

    // Monitor: drain this cycle's expectations and check popped data.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = exp_q.pop_front();
            a = actual(e.fld);
            n_chk++;
            if (a !== 32'(e.val))
                $display("FAIL %s/%s: got %0h want %0h", e.tag, e.fld.name(), a, e.val);
            else
                n_pass++;
        end
        if (bus.read === 1'b1) begin
            n_chk++;
            if (data_exp.size() == 0) begin
                $display("FAIL data: unexpected read, got %0h", mem_out);
            end else begin
                logic [11:0] d;
                d = data_exp.pop_front();
                if (mem_out !== d)
                    $display("FAIL data: got %0h want %0h", mem_out, d);
                else
                    n_pass++;
            end
        end
    end

    task automatic hexp(string tag, fld_e f, int v);
        exp_t e;
        e.tag = tag; e.fld = f; e.val = v;
        exp_q.push_back(e);
    endtask

    // One cycle: drive inputs, queue model expectations, advance model.
    task automatic step(bit p, bit q, logic [11:0] d, bit r, string tag, bit chk = 1'b1);
        bit ew, er, rp, rq;
        ew = !r && p && (m_cnt != 8 || q);
        er = !r && q && (m_cnt != 0);
        reset = r; bus.push = p; bus.pop = q; din = d;
        if (chk) begin
            hexp(tag, F_W, int'(ew));
            hexp(tag, F_R, int'(er));
            hexp(tag, F_PW, m_pw);
            hexp(tag, F_PR, m_pr);
            hexp(tag, F_CNT, m_cnt);
            hexp(tag, F_FULL, int'(m_cnt == 8));
            hexp(tag, F_EMPTY, int'(m_cnt == 0));
            hexp(tag, F_AF, int'(m_cnt >= 6));
            hexp(tag, F_AE, int'(m_cnt <= 2));
            hexp(tag, F_OV, m_ov);
            hexp(tag, F_UN, m_un);
        end
        if (er) data_exp.push_back(model_q.pop_front());
        if (ew) model_q.push_back(d);
        if (r) begin
            m_cnt = 0; m_pw = 0; m_pr = 0; m_ov = 0; m_un = 0;
            model_q.delete();
        end else begin
            rp = p && !ew;
            rq = q && !er;
            if (ew) m_pw = (m_pw + 1) % 8;
            if (er) m_pr = (m_pr + 1) % 8;
            m_cnt = m_cnt + int'(ew) - int'(er);
`ifdef FIFO_CTRL_STICKY_ERR_EN
            m_ov = m_ov | int'(rp);
            m_un = m_un | int'(rq);
`else
            m_ov = int'(rp);
            m_un = int'(rq);
`endif
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; din = '0;
        @(posedge clk);
        #1;

        // Reset with requests present: strobes forced low, reset state visible.
        step(1'b0, 1'b0, 12'h0, 1'b1, "rst0", 1'b0);
        hexp("rst", F_W, 0);
        hexp("rst", F_CNT, 0);
        hexp("rst", F_EMPTY, 1);
        hexp("rst", F_AE, 1);
        hexp("rst", F_FULL, 0);
        hexp("rst", F_AF, 0);
        step(1'b1, 1'b1, 12'h0, 1'b1, "rst");

        // Fill to full.
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin hexp("fill1", F_CNT, 1); hexp("fill1", F_EMPTY, 0); end
            if (i == 2) hexp("fill2", F_AE, 1);
            if (i == 3) hexp("fill3", F_AE, 0);
            if (i == 5) hexp("fill5", F_AF, 0);
            if (i == 6) begin hexp("fill6", F_AF, 1); hexp("fill6", F_FULL, 0); end
            step(1'b1, 1'b0, 12'(12'h100 + i), 1'b0, "fill");
        end
        hexp("full", F_CNT, 8);
        hexp("full", F_FULL, 1);
        hexp("full", F_PW, 0);

        // Rejected push while full.
        step(1'b0, 1'b0, 12'h0, 1'b0, "full_idle");
        hexp("ovf_push", F_W, 0);
        step(1'b1, 1'b0, 12'h0EE, 1'b0, "ovf_push");
        hexp("ovf", F_OV, 1);
        hexp("ovf", F_CNT, 8);
        step(1'b0, 1'b0, 12'h0, 1'b0, "ovf");
        for (int k = 0; k < 10; k++) begin
`ifdef FIFO_CTRL_STICKY_ERR_EN
            if (k == 9) hexp("ovf_late", F_OV, 1);
`else
            if (k == 9) hexp("ovf_late", F_OV, 0);
`endif
            step(1'b0, 1'b0, 12'h0, 1'b0, "ovf_wait");
        end

        // Full with simultaneous push and pop: oldest entry returned.
        hexp("fullpp", F_W, 1);
        hexp("fullpp", F_R, 1);
        step(1'b1, 1'b1, 12'hABC, 1'b0, "fullpp");
        hexp("fullpp_after", F_CNT, 8);
        hexp("fullpp_after", F_PW, 1);
        hexp("fullpp_after", F_PR, 1);
        step(1'b0, 1'b0, 12'h0, 1'b0, "fullpp_after");

        // Drain completely.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 12'h0, 1'b0, "drain");

        // Empty with simultaneous push and pop: only the push is taken.
        hexp("emptypp", F_W, 1);
        hexp("emptypp", F_R, 0);
        step(1'b1, 1'b1, 12'h055, 1'b0, "emptypp");
        hexp("emptypp_after", F_UN, 1);
        hexp("emptypp_after", F_CNT, 1);
        hexp("emptypp_after", F_R, 1);
        step(1'b0, 1'b1, 12'h0, 1'b0, "emptypp_after");
        hexp("emptied", F_CNT, 0);
        hexp("emptied", F_EMPTY, 1);
        step(1'b0, 1'b0, 12'h0, 1'b0, "emptied");

        // Rejected pop, partial fill, then reset together with a push.
        step(1'b0, 1'b1, 12'h0, 1'b0, "unf_pop");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 12'(12'h200 + i), 1'b0, "fill5");
        hexp("rst_push", F_W, 0);
        step(1'b1, 1'b0, 12'h3FF, 1'b1, "rst_push");
        hexp("rst_after", F_PW, 0);
        hexp("rst_after", F_PR, 0);
        hexp("rst_after", F_CNT, 0);
        hexp("rst_after", F_EMPTY, 1);
        hexp("rst_after", F_OV, 0);
        hexp("rst_after", F_UN, 0);
        step(1'b0, 1'b0, 12'h0, 1'b0, "rst_after");

        // Random traffic against the model.
        for (int i = 0; i < 20; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 12'($urandom_range(0, 4095)), 1'b0, "rand");
        step(1'b0, 1'b0, 12'h0, 1'b0, "tail");

        @(negedge clk);
        #1;
        n_chk++;
        if (data_exp.size() != 0)
            $display("FAIL leftover_data: got %0d pending want 0", data_exp.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller for the FIFO storage memory. It turns producer push and consumer pop requests into the memory's `write`/`read` strobes and `ptr_write`/`ptr_read` addresses. It also tracks occupancy and reports full, empty, almost-full, almost-empty and overflow/underflow status. Each FIFO instance has one `fifo_ctrl` next to its storage memory, which it drives directly.

## Interface
- `MAIN_QUEUE_SIZE`, default 3: pointer width; depth D = 2**MAIN_QUEUE_SIZE.
- `ALMOST_FULL_TH`, default 6: `almost_full` asserts when count >= this value.
- `ALMOST_EMPTY_TH`, default 2: `almost_empty` asserts when count <= this value.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high. The storage memory's `reset_L` is tied to `~reset`.
- `push` input 1: producer request to write one entry this cycle.
- `pop` input 1: consumer request to read one entry this cycle.
- `write` output 1: memory write strobe (combinational).
- `read` output 1: memory read strobe (combinational).
- `ptr_write` output MAIN_QUEUE_SIZE: memory write address (registered).
- `ptr_read` output MAIN_QUEUE_SIZE: memory read address (registered).
- `count` output MAIN_QUEUE_SIZE+1: occupancy, range 0..D (registered).
- `full` output 1: count == D (registered).
- `empty` output 1: count == 0 (registered).
- `almost_full` output 1: count >= ALMOST_FULL_TH (registered).
- `almost_empty` output 1: count <= ALMOST_EMPTY_TH (registered).
- `overflow` output 1: a push was rejected.
- `underflow` output 1: a pop was rejected.

## Operation
- Accept conditions:
  - `write = push & (~full | pop)`
  - `read = pop & ~empty`
- Accepted write: memory stores data at `ptr_write`; `ptr_write` increments modulo D.
- Accepted read: memory presents `mem[ptr_read]` combinationally in the same cycle; `ptr_read` increments modulo D.
- Count update per cycle:
  - +1 when write & ~read.
  - −1 when read & ~write.
  - Unchanged otherwise.
- Flags are recomputed from the next count value and registered, so they are consistent with `count` every cycle.
- Full with push and pop in the same cycle: both are accepted and count stays D. The read returns the old entry, because the memory write lands at the clock edge.
- Empty with push and pop in the same cycle: only the push is accepted (no read-through bypass). `underflow` fires and count goes to 1.
- Rejected push (full, no pop): no write, pointers hold, `overflow` fires.
- Rejected pop (empty): `read` = 0, `ptr_read` holds, `underflow` fires.
- Pointer wrap: D−1 → 0. With pointers equal, full and empty are disambiguated by count only.
- Reset (takes precedence over push/pop in the same cycle):
  - `ptr_write` = `ptr_read` = 0, count = 0.
  - `empty` = 1, `full` = 0, `almost_empty` = 1, `almost_full` = 0.
  - `overflow` = `underflow` = 0.
  - `write`/`read` are forced to 0 while reset is high.
  - Reset mid-operation discards all contents.

## Timing
- `write`/`read` respond combinationally to `push`/`pop` in the same cycle.
- Pointers, count and flags update on the rising edge after the accepted request.
- Pop-to-data latency is 0 cycles: data is valid on the memory's `data_out` in the cycle `read` is high.
- Push-to-visible latency is 1 cycle: an entry can be popped no earlier than the cycle after its push.
- `overflow`/`underflow` are registered and appear one cycle after the rejected request.

## Configuration
- `FIFO_CTRL_STICKY_ERR_EN` defined:
  - `overflow`/`underflow` are sticky; once set, they stay high until `reset`.
- `FIFO_CTRL_STICKY_ERR_EN` undefined:
  - Each error is a one-cycle pulse, high for exactly the cycle after each rejected request.
  - Back-to-back rejected requests give a continuous high.

## Test plan
Defaults throughout: D = 8, AF = 6, AE = 2.

- Reset, then 8 pushes with no pop:
  - count steps 1..8; `ptr_write` wraps to 0.
  - `almost_full` rises after the 6th push; `full` rises after the 8th.
  - `empty` falls after the 1st push; `almost_empty` falls after the 3rd.
- Full, push only:
  - `write` = 0, count stays 8, `overflow` = 1 next cycle.
  - Sticky build: still 1 ten cycles later. Pulse build: back to 0.
- Full, push & pop in the same cycle, data 0xABC:
  - `read` and `write` both = 1; count stays 8.
  - Both pointers advance by 1; the popped data is the oldest entry.
- Empty, push & pop in the same cycle:
  - `write` = 1, `read` = 0, count = 1, `underflow` = 1 next cycle.
  - Pop next cycle returns the pushed value and count returns to 0.
- Fill with 5 entries, then assert `reset` together with a push:
  - Next cycle: pointers = 0, count = 0, `empty` = 1, `write` = 0 during the reset cycle.
  - Error flags cleared.
- 20 cycles of random push/pop against a queue model:
  - Data order preserved, count matches the model every cycle.
  - No `write` while full without a pop; no `read` while empty.
